clk_div_multi: RTL and testbench

//  N-channel programmable clock/strobe divider; successor to the fixed single-channel divider.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_chan.sv | 82 ++++++++
 rtl/clk_div_multi.sv | 46 ++++
 tb/tb_clk_div_multi.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock/strobe divider.
package clk_div_pkg;

   localparam int unsigned CNT_W_DEF   = 28;
   localparam int unsigned DEF_DIV_DEF = 100000000;

   // Per-channel output mode.
   typedef enum logic {
      MODE_TOGGLE = 1'b0,
      MODE_PULSE  = 1'b1
   } mode_e;

   // Channel-select width; at least one bit even for a single channel.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadowed divide value, tick strobe and divided output.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int unsigned          CNT_W     = CNT_W_DEF,
   parameter logic [CNT_W-1:0]     DEF_DIV   = CNT_W'(DEF_DIV_DEF),
   parameter logic                 RESET_LVL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  mode_e            i_mode,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_pending,
   output logic             o_tick,
   output logic             o_clk_out
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_active;
   logic [CNT_W-1:0] r_shadow;
   logic             r_pending;
   logic             r_tick;
   logic             r_clk_out;

   logic             w_tc;
   logic             w_apply_now;

   // >= compare: active only changes while cnt is 0, so the counter never runs past it.
   assign w_tc        = (r_cnt >= r_active);
   // A new divide value may take effect at a period boundary or while the channel is idle.
   assign w_apply_now = !i_en || w_tc;

   // Counter, tick strobe and divided output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_tick    <= 1'b0;
         r_clk_out <= RESET_LVL;
      end else if (!i_en) begin
         r_cnt     <= '0;
         r_tick    <= 1'b0;
         r_clk_out <= RESET_LVL;
      end else if (w_tc) begin
         r_cnt     <= '0;
         r_tick    <= 1'b1;
         r_clk_out <= (i_mode == MODE_PULSE) ? 1'b1 : ~r_clk_out;
      end else begin
         r_cnt     <= r_cnt + CNT_W'(1);
         r_tick    <= 1'b0;
         if (i_mode == MODE_PULSE) begin
            r_clk_out <= 1'b0;
         end
      end
   end

   // Divide value shadowing: loads mid-period wait for the boundary, last load wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active  <= DEF_DIV;
         r_shadow  <= DEF_DIV;
         r_pending <= 1'b0;
      end else if (i_load) begin
         r_shadow <= i_load_val;
         if (w_apply_now) begin
            r_active  <= i_load_val;
            r_pending <= 1'b0;
         end else begin
            r_pending <= 1'b1;
         end
      end else if (r_pending && w_apply_now) begin
         r_active  <= r_shadow;
         r_pending <= 1'b0;
      end
   end

   assign o_pending = r_pending;
   assign o_tick    = r_tick;
   assign o_clk_out = r_clk_out;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock/strobe divider; the top only decodes load strobes.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter  int unsigned NUM_CH    = 4,
   parameter  int unsigned CNT_W     = CNT_W_DEF,
   parameter  int unsigned DEF_DIV   = DEF_DIV_DEF,
   parameter  logic        RESET_LVL = 1'b1,
   localparam int unsigned SEL_W     = sel_width(NUM_CH)
) (
   input  logic              Clk_in,
   input  logic              Reset,
   input  logic [NUM_CH-1:0] En,
   input  logic [NUM_CH-1:0] Mode,
   input  logic              Load,
   input  logic [SEL_W-1:0]  Load_sel,
   input  logic [CNT_W-1:0]  Load_val,
   output logic [NUM_CH-1:0] Pending,
   output logic [NUM_CH-1:0] Tick,
   output logic [NUM_CH-1:0] Clk_out
);

   logic [NUM_CH-1:0] w_load;

   // Selects beyond the last channel match no decode and are dropped.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_load[g] = Load && (Load_sel == SEL_W'(g));

      clk_div_chan #(
         .CNT_W     (CNT_W),
         .DEF_DIV   (CNT_W'(DEF_DIV)),
         .RESET_LVL (RESET_LVL)
      ) u_chan (
         .clk        (Clk_in),
         .rst_n      (Reset),
         .i_en       (En[g]),
         .i_mode     (mode_e'(Mode[g])),
         .i_load     (w_load[g]),
         .i_load_val (Load_val),
         .o_pending  (Pending[g]),
         .o_tick     (Tick[g]),
         .o_clk_out  (Clk_out[g])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi with a countdown-style reference model.
module tb_clk_div_multi;

   localparam int unsigned NUM_CH  = 4;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned DEF_DIV = 3;
   localparam int unsigned SEL_W   = 2;

   logic              Clk_in = 1'b0;
   logic              Reset;
   logic [NUM_CH-1:0] En;
   logic [NUM_CH-1:0] Mode;
   logic              Load;
   logic [SEL_W-1:0]  Load_sel;
   logic [CNT_W-1:0]  Load_val;
   logic [NUM_CH-1:0] Pending;
   logic [NUM_CH-1:0] Tick;
   logic [NUM_CH-1:0] Clk_out;

   int checks = 0;
   int errors = 0;

   // Model: period length is active+1 cycles; m_left counts edges remaining before the boundary edge.
   int m_active [NUM_CH];
   int m_shadow [NUM_CH];
   int m_left   [NUM_CH];
   bit m_pend   [NUM_CH];
   bit m_tick   [NUM_CH];
   bit m_clk    [NUM_CH];

   clk_div_multi #(
      .NUM_CH    (NUM_CH),
      .CNT_W     (CNT_W),
      .DEF_DIV   (DEF_DIV),
      .RESET_LVL (1'b1)
   ) dut (
      .Clk_in   (Clk_in),
      .Reset    (Reset),
      .En       (En),
      .Mode     (Mode),
      .Load     (Load),
      .Load_sel (Load_sel),
      .Load_val (Load_val),
      .Pending  (Pending),
      .Tick     (Tick),
      .Clk_out  (Clk_out)
   );

   always #5 Clk_in = ~Clk_in;

   function automatic void model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_active[i] = DEF_DIV;
         m_shadow[i] = DEF_DIV;
         m_left[i]   = DEF_DIV;
         m_pend[i]   = 1'b0;
         m_tick[i]   = 1'b0;
         m_clk[i]    = 1'b1;
      end
   endfunction

   function automatic void model_step();
      bit ld;
      bit bnd;
      int v;
      if (Reset !== 1'b1) begin
         model_reset();
         return;
      end
      v = int'(Load_val);
      for (int i = 0; i < NUM_CH; i++) begin
         ld = Load && (int'(Load_sel) == i);
         if (En[i]) begin
            bnd       = (m_left[i] == 0);
            m_tick[i] = bnd;
            if (Mode[i]) m_clk[i] = bnd;
            else if (bnd) m_clk[i] = !m_clk[i];
            if (ld) begin
               m_shadow[i] = v;
               if (bnd) begin
                  m_active[i] = v;
                  m_pend[i]   = 1'b0;
               end else begin
                  m_pend[i] = 1'b1;
               end
            end else if (bnd && m_pend[i]) begin
               m_active[i] = m_shadow[i];
               m_pend[i]   = 1'b0;
            end
            m_left[i] = bnd ? m_active[i] : m_left[i] - 1;
         end else begin
            m_tick[i] = 1'b0;
            m_clk[i]  = 1'b1;
            if (ld) begin
               m_shadow[i] = v;
               m_active[i] = v;
               m_pend[i]   = 1'b0;
            end else if (m_pend[i]) begin
               m_active[i] = m_shadow[i];
               m_pend[i]   = 1'b0;
            end
            m_left[i] = m_active[i];
         end
      end
   endfunction

   function automatic logic [3*NUM_CH-1:0] model_vec();
      logic [NUM_CH-1:0] p, t, c;
      for (int i = 0; i < NUM_CH; i++) begin
         p[i] = m_pend[i];
         t[i] = m_tick[i];
         c[i] = m_clk[i];
      end
      return {p, t, c};
   endfunction

   // Advance one clock: model follows the inputs sampled at posedge; outputs are read at negedge.
   task automatic step();
      @(posedge Clk_in);
      model_step();
      @(negedge Clk_in);
   endtask

   task automatic test_reset();
      Reset = 1'b0; En = '0; Mode = '0; Load = 1'b0; Load_sel = '0; Load_val = '0;
      model_reset();
      step();
      step();
      checks++;
      if ({Pending, Tick, Clk_out} !== 12'h00F) begin
         errors++;
         $display("FAIL reset_state got %h want %h", {Pending, Tick, Clk_out}, 12'h00F);
      end
   endtask

   task automatic test_toggle_default();
      logic [NUM_CH-1:0] exp_t, exp_c;
      Reset = 1'b1; En = '1; Mode = '0;
      for (int k = 1; k <= 16; k++) begin
         step();
         exp_t = (k % 4 == 0) ? 4'hF : 4'h0;
         exp_c = ((k / 4) % 2 == 0) ? 4'hF : 4'h0;
         checks++;
         if ({Pending, Tick, Clk_out} !== {4'h0, exp_t, exp_c}) begin
            errors++;
            $display("FAIL toggle_default k=%0d got %h want %h", k, {Pending, Tick, Clk_out}, {4'h0, exp_t, exp_c});
         end
      end
   endtask

   task automatic test_load_pending();
      int nt;
      step();
      Load = 1'b1; Load_sel = 2'd1; Load_val = 8'd1;
      step();
      Load = 1'b0;
      checks++;
      if (Pending[1] !== 1'b1) begin
         errors++;
         $display("FAIL pending_set got %b want 1", Pending[1]);
      end
      step();
      checks++;
      if ({Pending[1], Tick[1]} !== 2'b10) begin
         errors++;
         $display("FAIL pending_hold got %b want 10", {Pending[1], Tick[1]});
      end
      step();
      checks++;
      if ({Pending[1], Tick[1]} !== 2'b01) begin
         errors++;
         $display("FAIL pending_apply got %b want 01", {Pending[1], Tick[1]});
      end
      nt = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         nt += int'(Tick[1]);
         checks++;
         if ({Pending, Tick, Clk_out} !== model_vec()) begin
            errors++;
            $display("FAIL load_pending_model k=%0d got %h want %h", k, {Pending, Tick, Clk_out}, model_vec());
         end
      end
      checks++;
      if (nt != 4) begin
         errors++;
         $display("FAIL div1_tick_count got %0d want 4", nt);
      end
   endtask

   task automatic test_load_on_tc();
      bit found = 1'b0;
      logic prev;
      for (int k = 0; k < 10 && !found; k++) begin
         if (m_left[2] == 0) found = 1'b1;
         else step();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL tc_wait_ch2 got timeout want boundary");
      end
      Load = 1'b1; Load_sel = 2'd2; Load_val = 8'd0;
      step();
      Load = 1'b0;
      checks++;
      if ({Pending[2], Tick[2]} !== 2'b01) begin
         errors++;
         $display("FAIL load_on_tc got %b want 01", {Pending[2], Tick[2]});
      end
      for (int k = 0; k < 6; k++) begin
         prev = Clk_out[2];
         step();
         checks++;
         if ({Tick[2], Clk_out[2]} !== {1'b1, ~prev}) begin
            errors++;
            $display("FAIL div0_half_rate k=%0d got %b want %b", k, {Tick[2], Clk_out[2]}, {1'b1, ~prev});
         end
      end
   endtask

   task automatic test_pulse_last_wins();
      bit found = 1'b0;
      int nt, nh;
      Mode[3] = 1'b1;
      for (int k = 0; k < 10 && !found; k++) begin
         if (m_left[3] == 3) found = 1'b1;
         else step();
      end
      Load = 1'b1; Load_sel = 2'd3; Load_val = 8'd2;
      step();
      Load_val = 8'd5;
      step();
      Load = 1'b0;
      checks++;
      if (!found || Pending[3] !== 1'b1) begin
         errors++;
         $display("FAIL pulse_pending got %b found %0d want 1", Pending[3], found);
      end
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (Tick[3] === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || Pending[3] !== 1'b0) begin
         errors++;
         $display("FAIL pulse_boundary got pend %b found %0d want 0 1", Pending[3], found);
      end
      nt = 0; nh = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         nt += int'(Tick[3]);
         nh += int'(Clk_out[3]);
         checks++;
         if (Clk_out[3] !== Tick[3]) begin
            errors++;
            $display("FAIL pulse_eq_tick k=%0d got %b want %b", k, Clk_out[3], Tick[3]);
         end
      end
      checks++;
      if (nt != 2 || nh != 2) begin
         errors++;
         $display("FAIL pulse_duty got ticks %0d highs %0d want 2 2", nt, nh);
      end
   endtask

   task automatic test_disable();
      bit found = 1'b0;
      int n = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         if (m_left[0] == 1) found = 1'b1;
         else step();
      end
      En[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if ({Tick[0], Clk_out[0]} !== 2'b01) begin
            errors++;
            $display("FAIL disabled_out k=%0d got %b want 01", k, {Tick[0], Clk_out[0]});
         end
      end
      En[0] = 1'b1;
      found = 1'b0;
      for (int k = 1; k <= 20 && !found; k++) begin
         step();
         if (Tick[0] === 1'b1) begin
            found = 1'b1;
            n = k;
         end
      end
      checks++;
      if (n != 4 || Clk_out[0] !== 1'b0) begin
         errors++;
         $display("FAIL reenable_first_tick got %0d clk %b want 4 0", n, Clk_out[0]);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         En       = ($urandom_range(0, 7) == 0) ? 4'($urandom) : En | 4'($urandom);
         if ($urandom_range(0, 15) == 0) Mode = 4'($urandom);
         Load     = ($urandom_range(0, 3) == 0);
         Load_sel = 2'($urandom);
         Load_val = 8'($urandom_range(0, 6));
         step();
         checks++;
         if ({Pending, Tick, Clk_out} !== model_vec()) begin
            errors++;
            $display("FAIL random k=%0d got %h want %h", k, {Pending, Tick, Clk_out}, model_vec());
         end
      end
      Load = 1'b0;
   endtask

   task automatic test_async_reset();
      En = '1; Mode = '0;
      step();
      #2;
      Reset = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({Pending, Tick, Clk_out} !== 12'h00F) begin
         errors++;
         $display("FAIL async_reset got %h want %h", {Pending, Tick, Clk_out}, 12'h00F);
      end
      @(negedge Clk_in);
      Load = 1'b1; Load_sel = 2'd0; Load_val = 8'd1;
      step();
      step();
      checks++;
      if ({Pending, Tick, Clk_out} !== 12'h00F) begin
         errors++;
         $display("FAIL reset_hold got %h want %h", {Pending, Tick, Clk_out}, 12'h00F);
      end
      Load = 1'b0;
      Reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++;
         if (Tick[0] !== ((k % 4) == 0) || {Pending, Tick, Clk_out} !== model_vec()) begin
            errors++;
            $display("FAIL post_reset k=%0d got %h want %h", k, {Pending, Tick, Clk_out}, model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_toggle_default();
      test_load_pending();
      test_load_on_tc();
      test_pulse_last_wins();
      test_disable();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
